// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor / resolve-queue pair.
// Holds default sizing for the resolve queue and the encoding of a branch
// outcome, so predictor and queue agree on what "taken" means.
package branch_pkg;

    localparam int unsigned DEPTH_DEF     = 4;
    localparam int unsigned CNT_WIDTH_DEF = 16;

    localparam logic OUTCOME_TAKEN     = 1'b1;
    localparam logic OUTCOME_NOT_TAKEN = 1'b0;

endpackage

// File: rtl/pred_fifo.sv
// pred_fifo: 1-bit circular buffer holding in-flight branch predictions.
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   push, push_data write push_data at the write pointer
//   pop             retire the entry at the read pointer
//   flush           discard everything, including a same-cycle push
//   head            entry at the read pointer (oldest prediction)
//   occupancy       entries currently held
//   full            occupancy == DEPTH
// Caller guarantees push only when !full and pop only when occupancy != 0.
module pred_fifo
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     head,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [OW-1:0]    occ_q, occ_d;

    always_comb begin
        wr_d  = push ? wr_q + PW'(1) : wr_q;
        // On flush the read pointer catches up with the (possibly advanced)
        // write pointer, so a same-cycle push is discarded as well.
        rd_d  = flush ? wr_d : (pop ? rd_q + PW'(1) : rd_q);
        occ_d = flush ? '0 : occ_q + OW'(push) - OW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_data;
            end
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    assign head      = mem_q[rd_q];
    assign occupancy = occ_q;
    assign full      = (occ_q == OW'(DEPTH));

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: pairs issued predictions with resolved outcomes in
// order, emits the registered predictor update strobe, flags and flushes on
// mispredictions, and keeps saturating accuracy counters.
// Ports:
//   clk, rst               rising-edge clock, async active-high reset
//   pred_valid/pred_taken  prediction issued this cycle
//   pred_ready             queue not full (from registered state only)
//   res_valid/res_taken    oldest outstanding branch resolves
//   upd_valid/upd_taken    one-cycle predictor update, actual direction
//   mispredict             one-cycle pulse on a prediction/outcome mismatch
//   occupancy              entries held
//   total_cnt/miss_cnt     saturating resolution / misprediction counts
//   res_err                sticky: resolution seen with queue empty
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pred_valid,
    input  logic                   pred_taken,
    output logic                   pred_ready,
    input  logic                   res_valid,
    input  logic                   res_taken,
    output logic                   upd_valid,
    output logic                   upd_taken,
    output logic                   mispredict,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_WIDTH-1:0]   total_cnt,
    output logic [CNT_WIDTH-1:0]   miss_cnt,
    output logic                   res_err
);

    logic push, pop, miss;
    logic head, full;
    logic [$clog2(DEPTH):0] occ;

    logic                 upd_valid_q, upd_taken_q, mispredict_q, res_err_q;
    logic [CNT_WIDTH-1:0] total_q, miss_q;

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pred_taken),
        .pop       (pop),
        .flush     (miss),
        .head      (head),
        .occupancy (occ),
        .full      (full)
    );

    assign pred_ready = !full;
    assign push       = pred_valid && !full;
    assign pop        = res_valid && (occ != '0);
    assign miss       = pop && (head != res_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid_q  <= 1'b0;
            upd_taken_q  <= OUTCOME_NOT_TAKEN;
            mispredict_q <= 1'b0;
            res_err_q    <= 1'b0;
            total_q      <= '0;
            miss_q       <= '0;
        end else begin
            upd_valid_q  <= pop;
            mispredict_q <= miss;
            if (pop) begin
                upd_taken_q <= res_taken;
            end
            if (pop && (total_q != '1)) begin
                total_q <= total_q + 1'b1;
            end
            if (miss && (miss_q != '1)) begin
                miss_q <= miss_q + 1'b1;
            end
            if (res_valid && (occ == '0)) begin
                res_err_q <= 1'b1;
            end
        end
    end

    assign upd_valid  = upd_valid_q;
    assign upd_taken  = upd_taken_q;
    assign mispredict = mispredict_q;
    assign occupancy  = occ;
    assign total_cnt  = total_q;
    assign miss_cnt   = miss_q;
    assign res_err    = res_err_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
    logic pred_ready, upd_valid, upd_taken, mispredict, res_err;
    logic [2:0]    occupancy;
    logic [CW-1:0] total_cnt, miss_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    branch_resolve_queue #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_ready (pred_ready),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .upd_valid  (upd_valid),
        .upd_taken  (upd_taken),
        .mispredict (mispredict),
        .occupancy  (occupancy),
        .total_cnt  (total_cnt),
        .miss_cnt   (miss_cnt),
        .res_err    (res_err)
    );

    always #5 clk = ~clk;

    // Reference model: queue of predictions plus plain integer statistics.
    bit mq[$];
    int m_total, m_miss;
    bit m_uv, m_ut, m_mis, m_err;

    task automatic model_reset();
        mq.delete();
        m_total = 0; m_miss = 0;
        m_uv = 0; m_ut = 0; m_mis = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit pv, input bit pt, input bit rv, input bit rt);
        bit ready;
        bit oldest;
        bit missed;
        ready  = (mq.size() != DEPTH);
        missed = 0;
        m_uv   = 0;
        m_mis  = 0;
        if (rv && mq.size() > 0) begin
            oldest  = mq.pop_front();
            m_uv    = 1;
            m_ut    = rt;
            m_total = (m_total < CMAX) ? m_total + 1 : CMAX;
            if (oldest != rt) begin
                missed = 1;
                m_mis  = 1;
                m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
            end
        end else if (rv) begin
            m_err = 1;
        end
        if (pv && ready) mq.push_back(pt);
        if (missed) mq.delete();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".upd_valid"},  upd_valid,  m_uv);
        chk({tag, ".upd_taken"},  upd_taken,  m_ut);
        chk({tag, ".mispredict"}, mispredict, m_mis);
        chk({tag, ".occupancy"},  occupancy,  mq.size());
        chk({tag, ".pred_ready"}, pred_ready, mq.size() != DEPTH);
        chk({tag, ".total_cnt"},  total_cnt,  m_total);
        chk({tag, ".miss_cnt"},   miss_cnt,   m_miss);
        chk({tag, ".res_err"},    res_err,    m_err);
    endtask

    // Called just after an edge; drives inputs, advances one edge, compares.
    task automatic step(input string tag, input bit pv, input bit pt, input bit rv, input bit rt);
        pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
        @(posedge clk);
        #1;
        model_edge(pv, pt, rv, rt);
        pred_valid = 0; res_valid = 0;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        compare_all("reset");
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    typedef struct {
        bit pv, pt, rv, rt;
        bit e_uv, e_ut, e_mis;
        int e_occ;
    } vec_t;

    vec_t tbl[7];

    initial begin
        // push T,N,T then resolve 1,0,1 then idle (upd_taken holds)
        tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 1};
        tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 2};
        tbl[2] = '{1, 1, 0, 0, 0, 0, 0, 3};
        tbl[3] = '{0, 0, 1, 1, 1, 1, 0, 2};
        tbl[4] = '{0, 0, 1, 0, 1, 0, 0, 1};
        tbl[5] = '{0, 0, 1, 1, 1, 1, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 1, 0, 0};

        @(posedge clk); #1;
        do_reset();

        foreach (tbl[i]) begin
            step("tbl", tbl[i].pv, tbl[i].pt, tbl[i].rv, tbl[i].rt);
            chk("tbl.uv",  upd_valid,  tbl[i].e_uv);
            chk("tbl.ut",  upd_taken,  tbl[i].e_ut);
            chk("tbl.mis", mispredict, tbl[i].e_mis);
            chk("tbl.occ", occupancy,  tbl[i].e_occ);
        end
        chk("seq1.total", total_cnt, 3);
        chk("seq1.miss",  miss_cnt,  0);

        // Fill, then a 5th push is dropped.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step("fill", 1, i[0], 0, 0);
        chk("full.ready", pred_ready, 0);
        step("drop", 1, 0, 0, 0);
        chk("drop.occ", occupancy, 4);

        // Push 1,1,1; resolve 0 -> flush; later resolve sets res_err.
        do_reset();
        for (int i = 0; i < 3; i++) step("p111", 1, 1, 0, 0);
        step("miss", 0, 0, 1, 0);
        chk("miss.pulse", mispredict, 1);
        chk("miss.cnt",   miss_cnt,   1);
        chk("miss.occ",   occupancy,  0);
        step("mis_idle", 0, 0, 0, 0);
        chk("miss.pulse_end", mispredict, 0);
        step("err", 0, 0, 1, 1);
        chk("err.flag", res_err, 1);
        chk("err.noupd", upd_valid, 0);

        // Occ 2: push + matching resolve; then push + mismatching resolve.
        do_reset();
        step("o2a", 1, 1, 0, 0);
        step("o2b", 1, 0, 0, 0);
        step("pr_match", 1, 1, 1, 1);
        chk("prm.occ", occupancy, 2);
        chk("prm.uv",  upd_valid, 1);
        step("pr_miss", 1, 1, 1, 1);
        chk("prx.occ", occupancy, 0);
        chk("prx.mis", mispredict, 1);

        // 12 push/resolve pairs wrap pointers three times.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            automatic bit v = $urandom_range(0, 1);
            step("wrap_p", 1, v, 0, 0);
            step("wrap_r", 0, 0, 1, v);
            chk("wrap.ut", upd_taken, v);
        end
        chk("wrap.miss", miss_cnt, 0);

        // 17 resolutions saturate a 4-bit counter at 15.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step("sat_p", 1, 0, 0, 0);
            step("sat_r", 0, 0, 1, 0);
        end
        chk("sat.total", total_cnt, CMAX);

        // Async reset mid-resolve with occupancy 3.
        do_reset();
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 0, 0);
        res_valid = 1; res_taken = 1;
        #2;
        rst = 1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk); #1;
        compare_all("rst_held");
        res_valid = 0;
        rst = 0;
        step("post_rst", 0, 0, 0, 0);
        chk("post_rst.uv", upd_valid, 0);

        // Randomized traffic against the model; resolutions mostly match.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            automatic bit pv = ($urandom_range(0, 2) != 0);
            automatic bit pt = $urandom_range(0, 1);
            automatic bit rv = ($urandom_range(0, 2) == 0);
            automatic bit rt = $urandom_range(0, 1);
            if (mq.size() > 0) rt = ($urandom_range(0, 4) == 0) ? !mq[0] : mq[0];
            step("rand", pv, pt, rv, rt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks in-flight branch predictions between prediction and resolution. Sits directly downstream of the saturating-counter predictor: captures each issued `prediction`, pairs it in order with the actual outcome when the branch resolves, and generates the registered `taken` update pulse that trains the predictor. Also flags mispredictions, flushes younger predictions on a miss, and keeps saturating accuracy statistics.

## Interface
- `DEPTH`, 4: outstanding prediction slots; power of two, 2..16.
- `CNT_WIDTH`, 16: width of statistic counters.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pred_valid`  in  1  a prediction is issued this cycle.
- `pred_taken`  in  1  predicted direction (predictor `prediction`).
- `pred_ready`  out  1  queue can accept a prediction (not full).
- `res_valid`  in  1  oldest outstanding branch resolves this cycle.
- `res_taken`  in  1  actual direction.
- `upd_valid`  out  1  one-cycle pulse; predictor update strobe.
- `upd_taken`  out  1  actual direction for the update (drives predictor `taken`).
- `mispredict`  out  1  one-cycle pulse; resolved outcome differed from queued prediction.
- `occupancy`  out  $clog2(DEPTH)+1  entries currently held.
- `total_cnt`  out  CNT_WIDTH  resolutions accepted, saturating.
- `miss_cnt`  out  CNT_WIDTH  mispredictions, saturating.
- `res_err`  out  1  sticky: resolution arrived with queue empty.

## Operation
- Storage: circular buffer of DEPTH 1-bit entries, read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, separate occupancy register.
- Push: `pred_valid && pred_ready` writes `pred_taken` at write pointer and advances it.
- `pred_ready = (occupancy != DEPTH)`, from registered state only; no same-cycle bypass from a resolution. `pred_valid` while full is dropped, no state change.
- Resolve: `res_valid` with occupancy > 0 pops oldest entry, compares against `res_taken`.
  - Next cycle: `upd_valid`=1, `upd_taken`=`res_taken`, `total_cnt`+1.
  - Mismatch: `mispredict`=1 next cycle, `miss_cnt`+1, and every entry (remaining plus any same-cycle push) is discarded: occupancy=0, read pointer set equal to write pointer.
- `res_valid` with occupancy 0: ignored, no update pulse, `res_err` set and held until reset.
- Simultaneous push and resolve, match: both take effect, occupancy unchanged.
- Counters saturate at all-ones; no wrap.
- `upd_taken` holds its last value when `upd_valid`=0.

## Timing
- Reset (async, immediate): pointers 0, occupancy 0, `pred_ready`=1, `upd_valid`=0, `upd_taken`=0, `mispredict`=0, counters 0, `res_err`=0. Reset mid-operation discards all entries with no pulse.
- Push-to-visible: entry counted in `occupancy` the cycle after acceptance; resolvable from that cycle.
- Resolve-to-update latency: exactly 1 cycle; `upd_valid`, `mispredict`, counters all change on the same edge.
- Flush takes effect on the edge after the mispredicting resolution; `pred_ready` returns to 1 that cycle.
- All outputs registered; no combinational path from inputs to outputs except none (`pred_ready` from state).

## Structure
- Shared package `branch_pkg`: `DEPTH` default, `CNT_WIDTH` default, and `OUTCOME_TAKEN`/`OUTCOME_NOT_TAKEN` constants shared with the predictor.
- One sub-module: `pred_fifo` (parameterised 1-bit circular buffer with push, pop, flush, occupancy). Comparison, pulse generation, counters and error flag stay in the top.

## Test plan
- Reset, push T,N,T (1,0,1), resolve 1,0,1 -> three `upd_valid` pulses with `upd_taken` 1,0,1, `mispredict` never set, `total_cnt`=3, `miss_cnt`=0, occupancy 0.
- Fill DEPTH=4 entries, drive a 5th push -> `pred_ready`=0, 5th dropped, occupancy stays 4.
- Push 1,1,1; resolve 0 -> `mispredict`=1 next cycle, `miss_cnt`=1, occupancy 0, later resolution sets `res_err`.
- Occupancy 2, push and matching resolve same cycle -> occupancy 2, one `upd_valid`; with mismatching resolve instead -> occupancy 0, pushed entry flushed.
- Run 12 push/resolve pairs wrapping pointers three times -> all outcomes pair in order; preload counters near all-ones (CNT_WIDTH=4, 17 resolutions) -> `total_cnt` stays 15.
- Assert `rst` with occupancy 3 mid-resolve -> all outputs return to reset values immediately, no `upd_valid` pulse.
